// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter with byte-enable read-modify-write merge.
// Build option: define DMEM_ARB_RR_EN for round-robin, else port 0 has fixed priority.
module dmem_arbiter #(
  parameter int unsigned DEPTH_WORDS = 32,
  parameter int unsigned ADDR_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            req_i,
  input  logic [1:0]            we_i,
  input  logic [2*ADDR_W-1:0]   addr_i,
  input  logic [63:0]           wdata_i,
  input  logic [7:0]            be_i,
  output logic [1:0]            gnt_o,
  output logic [1:0]            rvalid_o,
  output logic [31:0]           rdata_o,
  output logic                  err_o,
  output logic [ADDR_W-1:0]     mem_addr_o,
  output logic                  mem_wr_en_o,
  output logic [31:0]           mem_wdata_o,
  input  logic [31:0]           mem_rdata_i
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;
  localparam int unsigned IDX_W  = ADDR_W - 2;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                we_q;
  logic [IDX_W-1:0]    idx_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [BE_W-1:0]     be_q;
  logic                port_q;
  logic [1:0]          rvalid_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                err_q;

  logic [1:0]          win_c;
  logic                sel_c;
  logic                pref1_c;
  logic                accept_c;
  logic                in_range_c;
  logic [DATA_W-1:0]   merged_c;
  logic                unused_c;

  // Byte-offset bits are meaningless for word accesses.
  assign unused_c = ^{addr_i[1:0], addr_i[ADDR_W+1:ADDR_W]};

`ifdef DMEM_ARB_RR_EN
  logic rr_q;

  // Pointer moves to the port that was not just served.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q <= 1'b0;
    end else if (accept_c) begin
      rr_q <= ~sel_c;
    end
  end

  assign pref1_c = rr_q;
`else
  assign pref1_c = 1'b0;
`endif

  assign win_c      = (req_i == 2'b11) ? (pref1_c ? 2'b10 : 2'b01) : req_i;
  assign sel_c      = win_c[1];
  assign accept_c   = (state_q == S_IDLE) && (|(req_i & win_c));
  assign in_range_c = ({1'b0, idx_q} < (IDX_W+1)'(DEPTH_WORDS));

  always_comb begin
    merged_c = mem_rdata_i;
    for (int n = 0; n < int'(BE_W); n++) begin
      if (be_q[n]) begin
        merged_c[8*n +: 8] = wdata_q[8*n +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (accept_c) state_d = S_ACCESS;
      S_ACCESS: state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    gnt_o       = 2'b00;
    mem_addr_o  = '0;
    mem_wr_en_o = 1'b0;
    mem_wdata_o = '0;
    case (state_q)
      S_IDLE: gnt_o = win_c;
      S_ACCESS: begin
        mem_addr_o = {idx_q, 2'b00};
        if (we_q) begin
          mem_wdata_o = merged_c;
          mem_wr_en_o = (be_q != '0) && in_range_c;
        end
      end
      default: ;
    endcase
  end

  // Request capture on acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      port_q  <= 1'b0;
    end else if (accept_c) begin
      port_q  <= sel_c;
      we_q    <= sel_c ? we_i[1] : we_i[0];
      idx_q   <= sel_c ? addr_i[2*ADDR_W-1:ADDR_W+2] : addr_i[ADDR_W-1:2];
      wdata_q <= sel_c ? wdata_i[63:32] : wdata_i[31:0];
      be_q    <= sel_c ? be_i[7:4] : be_i[3:0];
    end
  end

  // Response registers are loaded in ACCESS so they are visible during RESP only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_q <= 2'b00;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else if (state_q == S_ACCESS) begin
      rvalid_q <= port_q ? 2'b10 : 2'b01;
      rdata_q  <= (!we_q && in_range_c) ? mem_rdata_i : '0;
      err_q    <= !in_range_c;
    end else begin
      rvalid_q <= 2'b00;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end
  end

  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
  assign err_o    = err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 32-word memory.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_i;
  logic [1:0]  we_i;
  logic [63:0] addr_i;
  logic [63:0] wdata_i;
  logic [7:0]  be_i;
  logic [1:0]  gnt_o;
  logic [1:0]  rvalid_o;
  logic [31:0] rdata_o;
  logic        err_o;
  logic [31:0] mem_addr_o;
  logic        mem_wr_en_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;

  logic [31:0] mem [32];
  logic        clear_mem;
  int          checks = 0;
  int          errors = 0;
  int          rr_exp = 0;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .be_i(be_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o),
    .rdata_o(rdata_o), .err_o(err_o), .mem_addr_o(mem_addr_o),
    .mem_wr_en_o(mem_wr_en_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
  );

  assign mem_rdata_i = mem[mem_addr_o[6:2]];

  always @(posedge clk) begin
    if (clear_mem) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'h0;
    end else if (mem_wr_en_o) begin
      mem[mem_addr_o[6:2]] <= mem_wdata_o;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%08h exp 0x%08h", tag, got, exp);
    end
  endtask

  // One complete transaction from a requester; starts and ends at a negedge in IDLE.
  task automatic run_txn(input int p, input logic we, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [3:0] be,
                         input logic exp_wr, input logic [31:0] exp_wdata,
                         input logic [31:0] exp_rdata, input logic exp_err);
    logic [1:0] oh;
    int n;
    oh = (p == 1) ? 2'b10 : 2'b01;
    we_i[p] = we;
    addr_i[p*32 +: 32] = addr;
    wdata_i[p*32 +: 32] = wd;
    be_i[p*4 +: 4] = be;
    req_i[p] = 1'b1;
    #1;
    n = 0;
    while (gnt_o !== oh && n < 8) begin
      @(negedge clk); #1;
      n++;
    end
    check("gnt", 32'(gnt_o), 32'(oh));
    if (gnt_o !== oh) begin
      req_i[p] = 1'b0;
      return;
    end
    @(posedge clk); #1;
    req_i[p] = 1'b0;
    rr_exp = 1 - p;
    @(negedge clk);
    check("acc_gnt", 32'(gnt_o), 32'h0);
    check("acc_wr_en", 32'(mem_wr_en_o), 32'(exp_wr));
    check("acc_addr", mem_addr_o, {addr[31:2], 2'b00});
    if (exp_wr) check("acc_wdata", mem_wdata_o, exp_wdata);
    @(negedge clk);
    check("resp_rvalid", 32'(rvalid_o), 32'(oh));
    check("resp_rdata", rdata_o, exp_rdata);
    check("resp_err", 32'(err_o), 32'(exp_err));
    @(negedge clk);
    check("idle_rvalid", 32'(rvalid_o), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] oh;
    int ep;
    rst_n = 1'b0; clear_mem = 1'b1;
    req_i = '0; we_i = '0; addr_i = '0; wdata_i = '0; be_i = '0;
    repeat (2) @(negedge clk);
    clear_mem = 1'b0;
    check("rst_gnt", 32'(gnt_o), 32'h0);
    check("rst_rvalid", 32'(rvalid_o), 32'h0);
    check("rst_rdata", rdata_o, 32'h0);
    check("rst_err", 32'(err_o), 32'h0);
    check("rst_wr_en", 32'(mem_wr_en_o), 32'h0);
    check("rst_mem_addr", mem_addr_o, 32'h0);
    rst_n = 1'b1;
    rr_exp = 0;
    repeat (2) @(negedge clk);
    check("idle_no_req_gnt", 32'(gnt_o), 32'h0);

    // Full-word write then readback.
    run_txn(0, 1'b1, 32'h8, 32'hDEADBEEF, 4'hF, 1'b1, 32'hDEADBEEF, 32'h0, 1'b0);
    run_txn(0, 1'b0, 32'h8, 32'h0, 4'hF, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0);

    // Single-byte merge from port 1; readback with nonzero byte offset.
    run_txn(1, 1'b1, 32'h8, 32'h0000AA00, 4'b0010, 1'b1, 32'hDEADAAEF, 32'h0, 1'b0);
    run_txn(1, 1'b0, 32'hB, 32'h0, 4'hF, 1'b0, 32'h0, 32'hDEADAAEF, 1'b0);

    // Range boundaries; word 0 is the alias a wrapping index would hit.
    run_txn(0, 1'b1, 32'h0, 32'h12345678, 4'hF, 1'b1, 32'h12345678, 32'h0, 1'b0);
    run_txn(0, 1'b1, 32'h7C, 32'hCAFEF00D, 4'hF, 1'b1, 32'hCAFEF00D, 32'h0, 1'b0);
    run_txn(1, 1'b0, 32'h7C, 32'h0, 4'hF, 1'b0, 32'h0, 32'hCAFEF00D, 1'b0);
    run_txn(0, 1'b0, 32'h80, 32'h0, 4'hF, 1'b0, 32'h0, 32'h0, 1'b1);
    run_txn(1, 1'b1, 32'h80, 32'hFFFFFFFF, 4'hF, 1'b0, 32'h0, 32'h0, 1'b1);
    run_txn(0, 1'b0, 32'hFFFFFFFC, 32'h0, 4'hF, 1'b0, 32'h0, 32'h0, 1'b1);
    run_txn(0, 1'b0, 32'h0, 32'h0, 4'hF, 1'b0, 32'h0, 32'h12345678, 1'b0);

    // Zero byte-enable write leaves memory untouched.
    run_txn(0, 1'b1, 32'h8, 32'h11111111, 4'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    run_txn(0, 1'b0, 32'h8, 32'h0, 4'hF, 1'b0, 32'h0, 32'hDEADAAEF, 1'b0);

    // Request withdrawn before the grant edge.
    we_i[1] = 1'b1; addr_i[63:32] = 32'h8; wdata_i[63:32] = 32'h0; be_i[7:4] = 4'hF;
    req_i[1] = 1'b1;
    #1 check("drop_gnt", 32'(gnt_o), 32'h2);
    #1 req_i[1] = 1'b0;
    @(posedge clk); #1;
    check("drop_mem_addr", mem_addr_o, 32'h0);
    @(negedge clk);
    check("drop_wr_en", 32'(mem_wr_en_o), 32'h0);
    @(negedge clk);
    check("drop_rvalid", 32'(rvalid_o), 32'h0);

    // Asynchronous reset in the middle of a write access.
    we_i[0] = 1'b1; addr_i[31:0] = 32'h10; wdata_i[31:0] = 32'h55555555; be_i[3:0] = 4'hF;
    req_i[0] = 1'b1;
    #1 check("t6_gnt", 32'(gnt_o), 32'h1);
    @(posedge clk); #1;
    req_i[0] = 1'b0;
    check("t6_wr_en_pre", 32'(mem_wr_en_o), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    check("t6_wr_en_rst", 32'(mem_wr_en_o), 32'h0);
    check("t6_mem_addr_rst", mem_addr_o, 32'h0);
    check("t6_mem_wdata_rst", mem_wdata_o, 32'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t6_rvalid_rst", 32'(rvalid_o), 32'h0);
    end
    rst_n = 1'b1;
    rr_exp = 0;

    // Both ports requesting continuously.
    we_i = 2'b00; addr_i = {32'h8, 32'h0}; be_i = 8'hFF;
    req_i = 2'b11;
    for (int k = 0; k < 4; k++) begin
      #1;
`ifdef DMEM_ARB_RR_EN
      ep = rr_exp;
`else
      ep = 0;
`endif
      oh = (ep == 1) ? 2'b10 : 2'b01;
      check("arb_gnt", 32'(gnt_o), 32'(oh));
      @(negedge clk);
      check("arb_acc_gnt", 32'(gnt_o), 32'h0);
      @(negedge clk);
      check("arb_rvalid", 32'(rvalid_o), 32'(oh));
      check("arb_rdata", rdata_o, (ep == 1) ? 32'hDEADAAEF : 32'h12345678);
      rr_exp = 1 - ep;
      @(negedge clk);
    end
    req_i = 2'b00;

    // Aborted write must not have reached memory.
    run_txn(0, 1'b0, 32'h10, 32'h0, 4'hF, 1'b0, 32'h0, 32'h0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
